// File: rtl/opt_route_perm.sv
// opt_route_perm: loads one replica route, applies copy / 2-opt reversal / or-opt rotation, streams it back.
// Ports: clk, reset (sync, active-high); start, mode, k, l, m request an operation;
//        busy, done, err report progress; rd_en/rd_addr/rd_data read the route RAM (1-cycle latency);
//        wr_valid/wr_ready/wr_addr/wr_data stream rewritten words in ascending address order.
// Option: define OPT_ROUTE_PERM_SKIP_EN to suppress words that hold no lane of [K,L-1].
module opt_route_perm #(
   parameter int CITY_W = 7,
   parameter int LANES  = 8,
   parameter int WORDS  = 8,
   parameter int POS_W  = $clog2(LANES*WORDS)+1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic [1:0]                mode,
   input  logic [POS_W-1:0]          k,
   input  logic [POS_W-1:0]          l,
   input  logic [POS_W-1:0]          m,
   output logic                      busy,
   output logic                      done,
   output logic                      err,
   output logic                      rd_en,
   output logic [$clog2(WORDS)-1:0]  rd_addr,
   input  logic [LANES*CITY_W-1:0]   rd_data,
   output logic                      wr_valid,
   input  logic                      wr_ready,
   output logic [$clog2(WORDS)-1:0]  wr_addr,
   output logic [LANES*CITY_W-1:0]   wr_data
);
   localparam int NP = LANES*WORDS;
   localparam int AW = $clog2(WORDS);
   localparam int LB = $clog2(LANES);
   localparam int IW = AW+LB;
   localparam int PW = POS_W+1;
   localparam logic [PW-1:0] NPV = PW'(NP);
   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DRAIN, S_EMIT, S_FIN, S_ERR} state_t;
   state_t r_state, w_next;
   logic [AW-1:0] r_cnt, r_cap_addr;
   logic r_cap_en;
   logic [1:0] r_mode;
   logic [PW-1:0] r_k, r_l, r_m;
   logic [CITY_W-1:0] r_buf [NP];
   logic [PW-1:0] w_k, w_l, w_m, w_lo;
   logic [PW-1:0] w_pos [LANES];
   logic [PW-1:0] w_src [LANES];
   logic w_legal, w_last, w_touch, w_adv;
   // one extra bit over POS_W so K+L and L-M never wrap
   assign w_k = {1'b0, k};
   assign w_l = {1'b0, l};
   assign w_m = {1'b0, m};
   assign w_legal = mode == 2'd0 ||
                    ((mode == 2'd1 || mode == 2'd2) && w_k < w_l && w_l <= NPV &&
                     (mode == 2'd1 || (w_m != '0 && w_m < w_l - w_k)));
   assign w_last = r_cnt == AW'(WORDS-1);
   assign w_lo = PW'({r_cnt, {LB{1'b0}}});
`ifdef OPT_ROUTE_PERM_SKIP_EN
   assign w_touch = r_mode != 2'd0 && w_lo < r_l && w_lo + PW'(LANES) > r_k;
`else
   assign w_touch = 1'b1;
`endif
   // skipped words still take one EMIT cycle so the done timing is unchanged
   assign w_adv = !w_touch || wr_ready;
   always_ff @(posedge clk)
      if (reset) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_cap_en   <= 1'b0;
         r_cap_addr <= '0;
         r_mode     <= '0;
         r_k        <= '0;
         r_l        <= '0;
         r_m        <= '0;
      end else begin
         r_state    <= w_next;
         r_cap_en   <= rd_en;
         r_cap_addr <= rd_addr;
         if (r_state == S_IDLE && start) begin
            r_mode <= mode;
            r_k    <= w_k;
            r_l    <= w_l;
            r_m    <= w_m;
         end
         if (r_state == S_LOAD || (r_state == S_EMIT && w_adv))
            r_cnt <= w_last ? '0 : r_cnt + AW'(1);
      end
   always_ff @(posedge clk)
      if (r_cap_en)
         for (int i = 0; i < LANES; i++)
            r_buf[{r_cap_addr, LB'(i)}] <= rd_data[i*CITY_W +: CITY_W];
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  w_next = !start ? S_IDLE : w_legal ? S_LOAD : S_ERR;
         S_LOAD:  w_next = w_last ? S_DRAIN : S_LOAD;
         S_DRAIN: w_next = S_EMIT;
         S_EMIT:  w_next = (w_adv && w_last) ? S_FIN : S_EMIT;
         default: w_next = S_IDLE;
      endcase
   end
   // source buffer index for each lane of the word being emitted
   always_comb
      for (int i = 0; i < LANES; i++) begin
         w_pos[i] = PW'({r_cnt, LB'(i)});
         w_src[i] = (r_mode == 2'd0 || w_pos[i] < r_k || w_pos[i] >= r_l) ? w_pos[i] :
                    r_mode == 2'd1 ? r_k + r_l - w_pos[i] - PW'(1) :
                    w_pos[i] < r_l - r_m ? w_pos[i] + r_m : w_pos[i] + r_k - (r_l - r_m);
      end
   always_comb begin
      busy     = r_state == S_LOAD || r_state == S_DRAIN || r_state == S_EMIT;
      done     = r_state == S_FIN || r_state == S_ERR;
      err      = r_state == S_ERR;
      rd_en    = r_state == S_LOAD;
      rd_addr  = rd_en ? r_cnt : '0;
      wr_valid = r_state == S_EMIT && w_touch;
      wr_addr  = r_state == S_EMIT ? r_cnt : '0;
      wr_data  = '0;
      for (int i = 0; i < LANES; i++)
         if (r_state == S_EMIT) wr_data[i*CITY_W +: CITY_W] = r_buf[IW'(w_src[i])];
   end
endmodule
